// File: rtl/post_ta.sv
// Winograd output transform: Y = A^T * M * A, one product row in per beat, one spatial row out per beat.
// de mode takes 6x6 tiles and produces 4x4; rf mode takes 4x4 tiles and produces 2x2.
module post_ta #(
    parameter int P_bits = 16,
    parameter int O_bits = P_bits + 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mode,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [6*P_bits-1:0]   in_row,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*O_bits-1:0]   out_row,
    output logic [1:0]            out_idx,
    output logic                  out_last,
    output logic                  out_mode
);

    localparam int R_W = P_bits + 5;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ACCUM = 2'd1;
    localparam logic [1:0] EMIT  = 2'd2;

    logic [1:0]             state;
    logic [2:0]             row_cnt;
    logic                   tile_mode;
    logic signed [R_W-1:0]  rbuf [0:5][0:3];

    logic                   cur_mode;
    logic                   accept;
    logic                   last_beat;
    logic signed [O_bits-1:0] e [0:5];
    logic signed [R_W-1:0]  rv [0:3];

    // One 1-D pass of A^T: output element j from six inputs. Shared by row and column passes.
    function automatic logic signed [O_bits-1:0] xform(
        input logic                     de,
        input logic [1:0]               j,
        input logic signed [O_bits-1:0] a0,
        input logic signed [O_bits-1:0] a1,
        input logic signed [O_bits-1:0] a2,
        input logic signed [O_bits-1:0] a3,
        input logic signed [O_bits-1:0] a4,
        input logic signed [O_bits-1:0] a5
    );
        logic signed [O_bits-1:0] s;
        s = '0;
        if (de) begin
            case (j)
                2'd0:    s = a0 + a1 + a2 + a3 + a4;
                2'd1:    s = a1 - a2 + (a3 <<< 1) - (a4 <<< 1);
                2'd2:    s = a1 + a2 + (a3 <<< 2) + (a4 <<< 2);
                default: s = a1 - a2 + (a3 <<< 3) - (a4 <<< 3) + a5;
            endcase
        end else begin
            case (j)
                2'd0:    s = a0 + a1 + a2;
                2'd1:    s = a1 - a2 - a3;
                default: s = '0;
            endcase
        end
        return s;
    endfunction

    // The first beat of a tile uses the live mode pin; later beats use the latched copy.
    assign cur_mode  = (state == IDLE) ? mode : tile_mode;
    assign in_ready  = (state != EMIT);
    assign accept    = in_valid && in_ready;
    assign last_beat = (row_cnt == (tile_mode ? 3'd5 : 3'd3)) && (state == ACCUM);

    always_comb begin
        for (int c = 0; c < 6; c++) begin
            e[c] = O_bits'($signed(in_row[c*P_bits +: P_bits]));
        end
        for (int j = 0; j < 4; j++) begin
            rv[j] = R_W'(xform(cur_mode, 2'(j), e[0], e[1], e[2], e[3], e[4], e[5]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row_cnt   <= 3'd0;
            out_idx   <= 2'd0;
            tile_mode <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                for (int j = 0; j < 4; j++) begin
                    rbuf[i][j] <= '0;
                end
            end
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        tile_mode <= mode;
                        row_cnt   <= 3'd1;
                        state     <= ACCUM;
                        for (int j = 0; j < 4; j++) rbuf[0][j] <= rv[j];
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        for (int j = 0; j < 4; j++) rbuf[row_cnt][j] <= rv[j];
                        if (last_beat) begin
                            row_cnt <= 3'd0;
                            out_idx <= 2'd0;
                            state   <= EMIT;
                        end else begin
                            row_cnt <= row_cnt + 3'd1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        if (out_last) begin
                            out_idx <= 2'd0;
                            state   <= IDLE;
                        end else begin
                            out_idx <= out_idx + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = (state == EMIT);
    assign out_last  = out_valid && (out_idx == (tile_mode ? 2'd3 : 2'd1));
    assign out_mode  = tile_mode;

    // Column pass is purely combinational over rbuf, which stays frozen for the whole EMIT phase.
    always_comb begin
        out_row = '0;
        if (state == EMIT) begin
            for (int j = 0; j < 4; j++) begin
                if (tile_mode || j < 2) begin
                    out_row[j*O_bits +: O_bits] = xform(tile_mode, out_idx,
                        O_bits'(rbuf[0][j]), O_bits'(rbuf[1][j]), O_bits'(rbuf[2][j]),
                        O_bits'(rbuf[3][j]), O_bits'(rbuf[4][j]), O_bits'(rbuf[5][j]));
                end
            end
        end
    end

endmodule

// File: tb/tb_post_ta.sv
// Bench for post_ta: directed and random tiles checked against a matrix-product model of A^T*M*A.
module tb_post_ta;

    localparam int P = 16;
    localparam int O = P + 10;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           mode;
    logic           in_valid;
    logic           in_ready;
    logic [6*P-1:0] in_row;
    logic           out_valid;
    logic           out_ready;
    logic [4*O-1:0] out_row;
    logic [1:0]     out_idx;
    logic           out_last;
    logic           out_mode;

    int     n_cmp = 0;
    int     n_bad = 0;
    int     m [6][6];
    longint y [4][4];
    int     atd [4][6] = '{'{1, 1, 1, 1, 1, 0}, '{0, 1, -1, 2, -2, 0},
                           '{0, 1, 1, 4, 4, 0}, '{0, 1, -1, 8, -8, 1}};
    int     atr [2][4] = '{'{1, 1, 1, 0}, '{0, 1, -1, -1}};

    always #5 clk = ~clk;

    post_ta #(.P_bits(P)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_row(in_row), .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
        .out_idx(out_idx), .out_last(out_last), .out_mode(out_mode)
    );

    function automatic longint at(input bit de, input int r, input int i);
        if (de) return longint'(atd[r][i]);
        if (r < 2 && i < 4) return longint'(atr[r][i]);
        return 0;
    endfunction

    // Reference: Y = A^T * M * A over the active N x N corner of m.
    function automatic void compute(input bit de);
        int n = de ? 6 : 4;
        int k = de ? 4 : 2;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                y[r][c] = 0;
                if (r < k && c < k) begin
                    for (int i = 0; i < n; i++)
                        for (int j = 0; j < n; j++)
                            y[r][c] += at(de, r, i) * longint'(m[i][j]) * at(de, c, j);
                end
            end
        end
    endfunction

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input int kind, input int v);
        for (int r = 0; r < 6; r++) begin
            for (int c = 0; c < 6; c++) begin
                case (kind)
                    0:       m[r][c] = v;
                    1:       m[r][c] = (r == 5 && c == 5) ? 1 : 0;
                    default: m[r][c] = int'($urandom_range(0, 65535)) - 32768;
                endcase
            end
        end
    endtask

    task automatic send_row(input bit md, input int r);
        int t = 0;
        for (int c = 0; c < 6; c++) in_row[c*P +: P] = 16'(m[r][c]);
        mode     = md;
        in_valid = 1'b1;
        while (!in_ready && t < 50) begin
            step();
            t++;
        end
        if (t == 50) chk("in_ready_wait", in_ready, 1);
        step();
    endtask

    task automatic send_tile(input bit md, input bit toggle);
        int n = md ? 6 : 4;
        for (int r = 0; r < n; r++) send_row((toggle && r > 0) ? ~md : md, r);
        in_valid = 1'b0;
        mode     = 1'b0;
    endtask

    task automatic check_row(input bit de, input int r);
        int k = de ? 4 : 2;
        logic signed [O-1:0] v;
        chk($sformatf("out_valid_r%0d", r), out_valid, 1);
        chk($sformatf("out_idx_r%0d", r), out_idx, r);
        chk($sformatf("out_last_r%0d", r), out_last, (r == k - 1) ? 1 : 0);
        chk($sformatf("out_mode_r%0d", r), out_mode, de);
        chk($sformatf("in_ready_emit_r%0d", r), in_ready, 0);
        for (int j = 0; j < 4; j++) begin
            v = out_row[j*O +: O];
            chk($sformatf("row%0d_el%0d", r, j), v, 32'(y[r][j]));
        end
    endtask

    // Stall cycles hold in_valid high to confirm the block does not swallow a beat during EMIT.
    task automatic recv_tile(input bit de, input int stall_row, input int stall_n, input bit rnd);
        int k = de ? 4 : 2;
        int ns;
        compute(de);
        for (int r = 0; r < k; r++) begin
            ns = (r == stall_row) ? stall_n : 0;
            if (rnd) ns = int'($urandom_range(0, 2));
            for (int s = 0; s <= ns; s++) begin
                out_ready = (s == ns);
                in_valid  = (s < ns);
                check_row(de, r);
                step();
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("in_ready_after", in_ready, 1);
        chk("out_valid_after", out_valid, 0);
    endtask

    task automatic chk_reset(input string tag);
        logic signed [O-1:0] v;
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_out_valid"}, out_valid, 0);
        chk({tag, "_out_last"}, out_last, 0);
        chk({tag, "_out_mode"}, out_mode, 0);
        chk({tag, "_out_idx"}, out_idx, 0);
        for (int j = 0; j < 4; j++) begin
            v = out_row[j*O +: O];
            chk($sformatf("%s_el%0d", tag, j), v, 0);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        mode      = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_row    = '0;
        #1;
        chk_reset("reset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        step();

        fill(0, 1);
        send_tile(1'b1, 1'b0);
        recv_tile(1'b1, -1, 0, 1'b0);

        fill(0, 1);
        send_tile(1'b0, 1'b0);
        recv_tile(1'b0, -1, 0, 1'b0);

        fill(1, 0);
        send_tile(1'b1, 1'b0);
        recv_tile(1'b1, -1, 0, 1'b0);
        fill(0, 1);
        send_tile(1'b0, 1'b1);
        recv_tile(1'b0, -1, 0, 1'b0);

        fill(0, 1);
        send_tile(1'b1, 1'b0);
        recv_tile(1'b1, 1, 3, 1'b0);

        fill(0, -32768);
        send_tile(1'b1, 1'b0);
        recv_tile(1'b1, -1, 0, 1'b0);

        for (int t = 0; t < 24; t++) begin
            bit de;
            de = 1'($urandom_range(0, 1));
            fill(2, 0);
            send_tile(de, 1'($urandom_range(0, 1)));
            recv_tile(de, -1, 0, 1'b1);
        end

        // Reset while a de tile is half loaded.
        fill(0, 1);
        for (int r = 0; r < 3; r++) send_row(1'b1, r);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_accum");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fill(0, 1);
        send_tile(1'b0, 1'b0);
        recv_tile(1'b0, -1, 0, 1'b0);

        // Reset in the middle of emitting a de tile.
        fill(2, 0);
        send_tile(1'b1, 1'b0);
        compute(1'b1);
        check_row(1'b1, 0);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_row(1'b1, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset("rst_emit");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        fill(0, 1);
        send_tile(1'b0, 1'b0);
        recv_tile(1'b0, -1, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
